uart_stream_ctrl: RTL and testbench

UART_STREAM_CTRL -- requirements
Module: uart_stream_ctrl

---
 rtl/uart_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_stream_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_ctrl.sv
// UART transmitter that either sweeps a printable-character pattern or echoes
// bytes captured into a small FIFO. Bit timing comes from a tick counter in the i_clk domain.
module uart_stream_ctrl #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PAT_START  = 32,
  parameter int PAT_END    = 126
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_mode,
  input  logic                                 i_start,
  input  logic [DATA_BITS-1:0]                 i_rx_data,
  input  logic                                 i_rx_valid,
  output logic                                 o_tx,
  output logic                                 o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count,
  output logic                                 o_fifo_full,
  output logic                                 o_fifo_empty,
  output logic                                 o_overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  localparam logic [DATA_BITS-1:0] PAT_S = DATA_BITS'(PAT_START);
  localparam logic [DATA_BITS-1:0] PAT_E = DATA_BITS'(PAT_END);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] pat;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  logic                 launch, pop, push, bit_end;
  logic [DATA_BITS-1:0] tx_byte;

  assign o_fifo_full  = (o_fifo_count == CW'(FIFO_DEPTH));
  assign o_fifo_empty = (o_fifo_count == '0);

  assign launch  = (state == S_IDLE) && (i_mode ? !o_fifo_empty : i_start);
  assign pop     = launch && i_mode;
  // A full FIFO can still take a byte in the same cycle one leaves for the line.
  assign push    = i_rx_valid && (!o_fifo_full || pop);
  assign bit_end = (tick == TW'(DIV-1));
  assign tx_byte = i_mode ? mem[rd_ptr] : pat;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      if (state == S_IDLE) tick <= '0;
      else                 tick <= bit_end ? '0 : tick + 1'b1;
      case (state)
        S_IDLE: if (launch) begin
          state   <= S_START;
          bit_cnt <= '0;
          shreg   <= tx_byte;
          o_tx    <= 1'b0;
          o_busy  <= 1'b1;
        end
        S_START: if (bit_end) begin
          state <= S_DATA;
          o_tx  <= shreg[0];
          shreg <= shreg >> 1;
        end
        S_DATA: if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS-1)) begin
            state <= S_STOP;
            o_tx  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        default: if (bit_end) begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                pat <= PAT_S;
    else if (launch && !i_mode) pat <= (pat == PAT_E) ? PAT_S : pat + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_fifo_count <= o_fifo_count + 1'b1;
        2'b01:   o_fifo_count <= o_fifo_count - 1'b1;
        default: o_fifo_count <= o_fifo_count;
      endcase
      if (i_rx_valid && !push) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rx_data;
  end

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Directed bench for uart_stream_ctrl at DIV=12: pattern sweep and wrap, echo order,
// FIFO overflow and full-with-pop, mid-frame reset.
module tb_uart_stream_ctrl;
  localparam int DIV = 12;
  localparam int FB  = 10 * DIV;

  logic       i_clk = 1'b0;
  logic       i_rst, i_mode, i_start, i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_tx, o_busy, o_fifo_full, o_fifo_empty, o_overflow;
  logic [4:0] o_fifo_count;

  int nvec = 0;
  int nerr = 0;

  uart_stream_ctrl #(
    .CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8), .FIFO_DEPTH(16),
    .PAT_START(32), .PAT_END(126)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_tx(o_tx), .o_busy(o_busy),
    .o_fifo_count(o_fifo_count), .o_fifo_full(o_fifo_full),
    .o_fifo_empty(o_fifo_empty), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of the frame against the
  // ideal waveform and returns on the negedge after the frame ends.
  task automatic rx_frame(input logic [7:0] exp, input string tag);
    int n, bad, idx;
    logic [9:0] fr;
    logic [7:0] got;
    fr = {1'b1, exp, 1'b0};
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_tx !== 1'b0 && n < 400);
    if (o_tx !== 1'b0) begin
      chk({tag, "_timeout"}, 32'd1, 32'd0);
      return;
    end
    bad = 0;
    got = '0;
    for (int s = 0; s < FB; s++) begin
      if (s > 0) @(negedge i_clk);
      if (o_tx !== fr[s/DIV] || o_busy !== 1'b1) bad++;
      if ((s % DIV) == DIV/2 && s >= DIV && s < 9*DIV) begin
        idx = s/DIV - 1;
        got[idx] = o_tx;
      end
    end
    @(negedge i_clk);
    chk({tag, "_byte"}, 32'(got), 32'(exp));
    chk({tag, "_shape"}, 32'(bad), 32'd0);
    chk({tag, "_end"}, {30'd0, o_busy, o_tx}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b0; i_mode = 1'b0; i_start = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_tx",    32'(o_tx), 32'd1);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    chk("rst_empty", 32'(o_fifo_empty), 32'd1);
    chk("rst_full",  32'(o_fifo_full), 32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);

    // Pattern sweep through the wrap; mode/start wiggled mid-frame on 0x22.
    i_start = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int v = 32; v <= 126; v++) begin
      if (v == 34) begin
        fork
          rx_frame(8'(v), "pat");
          begin
            repeat (30) @(negedge i_clk);
            i_start = 1'b0; i_mode = 1'b1;
            repeat (20) @(negedge i_clk);
            i_start = 1'b1; i_mode = 1'b0;
          end
        join
      end else rx_frame(8'(v), "pat");
    end
    rx_frame(8'h20, "wrap0");
    rx_frame(8'h21, "wrap1");
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("stop_busy", 32'(o_busy), 32'd0);

    // Echo order.
    i_mode = 1'b1;
    fork
      begin push(8'h41); push(8'h42); push(8'h43); end
      rx_frame(8'h41, "echo0");
    join
    rx_frame(8'h42, "echo1");
    rx_frame(8'h43, "echo2");
    chk("echo_empty", 32'(o_fifo_empty), 32'd1);
    chk("echo_count", 32'(o_fifo_count), 32'd0);

    // Pattern resumes where it left off after echo traffic.
    i_mode = 1'b0; i_start = 1'b1;
    rx_frame(8'h22, "pat_resume");
    i_start = 1'b0;

    // Overflow: 17 pushes during a frame, i_start high but ignored in echo mode.
    i_mode = 1'b1; i_start = 1'b1;
    fork
      begin
        push(8'h55);
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
      end
      rx_frame(8'h55, "ovf_first");
    join
    chk("ovf_count", 32'(o_fifo_count), 32'd16);
    chk("ovf_full",  32'(o_fifo_full), 32'd1);
    chk("ovf_flag",  32'(o_overflow), 32'd1);
    for (int i = 0; i < 16; i++) rx_frame(8'(8'h60 + i), "ovf_drain");
    repeat (30) @(negedge i_clk);
    chk("ovf_idle",   32'(o_busy), 32'd0);
    chk("ovf_empty",  32'(o_fifo_empty), 32'd1);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Full FIFO with a push landing on the echo launch edge.
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    chk("rst2_ovf", 32'(o_overflow), 32'd0);
    i_rst = 1'b1;
    fork
      begin
        push(8'h10);
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      end
      rx_frame(8'h10, "coin_first");
    join
    chk("coin_full_pre", 32'(o_fifo_full), 32'd1);
    fork
      begin
        i_rx_data = 8'h90; i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("coin_count", 32'(o_fifo_count), 32'd16);
        chk("coin_full",  32'(o_fifo_full), 32'd1);
        chk("coin_ovf",   32'(o_overflow), 32'd0);
      end
      rx_frame(8'h80, "coin_drain");
    join
    for (int i = 1; i < 16; i++) rx_frame(8'(8'h80 + i), "coin_drain");
    rx_frame(8'h90, "coin_new");
    chk("coin_empty", 32'(o_fifo_empty), 32'd1);
    chk("coin_ovf_end", 32'(o_overflow), 32'd0);

    // Reset 50 cycles into a pattern frame.
    i_mode = 1'b0; i_start = 1'b1;
    rx_frame(8'h20, "rst_a");
    repeat (51) @(negedge i_clk);
    chk("mid_busy_pre", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    #1;
    chk("mid_tx",   32'(o_tx), 32'd1);
    chk("mid_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    rx_frame(8'h20, "rst_b");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
